// File: rtl/ctrl_sequencer_if.sv
// Strobe/handshake bundle between the control sequencer and the CPU datapath.
// The datapath side (IR/flag registers, RAM, bench) uses master; the
// sequencer uses slave.
interface ctrl_sequencer_if #(
    parameter int OPC_W = 4
);
    // Datapath -> sequencer
    logic [OPC_W-1:0] IR;
    logic             EQ;
    logic             MI;
    logic             MEM_RDY;
    logic             RUN;

    // Sequencer -> datapath: one-hot state
    logic             FETCH;
    logic             EXEC1;
    logic             EXEC2;
    logic             HALTED;

    // Sequencer -> datapath: strobes and error flag
    logic             IR_LOAD;
    logic             EXTRA;
    logic             Wren;
    logic             MUX1;
    logic             MUX3;
    logic             MUX3_useAllBits;
    logic             PC_sload;
    logic             PC_cnt_en;
    logic             ACC_EN;
    logic             ACC_LOAD;
    logic             ACC_SHIFTIN;
    logic             ADDSUB;
    logic             ERR;

    modport master (
        output IR, EQ, MI, MEM_RDY, RUN,
        input  FETCH, EXEC1, EXEC2, HALTED,
        input  IR_LOAD, EXTRA, Wren, MUX1, MUX3, MUX3_useAllBits,
        input  PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, ERR
    );

    modport slave (
        input  IR, EQ, MI, MEM_RDY, RUN,
        output FETCH, EXEC1, EXEC2, HALTED,
        output IR_LOAD, EXTRA, Wren, MUX1, MUX3, MUX3_useAllBits,
        output PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, ERR
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Instruction-cycle sequencer and opcode decoder for the accumulator CPU.
// FETCH waits for RAM, EXEC1 decodes and issues single-cycle instructions,
// EXEC2 finishes memory-operand instructions, HALT waits for RUN.
// Strobes are combinational from state/IR/flags/MEM_RDY and are forced low
// while RESET is asserted.
module ctrl_sequencer #(
    parameter int OPC_W           = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    ctrl_sequencer_if.slave bus
);

    typedef logic [OPC_W-1:0] opc_t;

    // Full-width opcode constants: any value above SHL falls to the illegal
    // branch, so wide IRs never alias onto a legal opcode.
    localparam opc_t OP_LDA = opc_t'(0);
    localparam opc_t OP_STA = opc_t'(1);
    localparam opc_t OP_ADD = opc_t'(2);
    localparam opc_t OP_SUB = opc_t'(3);
    localparam opc_t OP_JMP = opc_t'(4);
    localparam opc_t OP_JMI = opc_t'(5);
    localparam opc_t OP_JEQ = opc_t'(6);
    localparam opc_t OP_STP = opc_t'(7);
    localparam opc_t OP_LDI = opc_t'(8);
    localparam opc_t OP_JNE = opc_t'(9);
    localparam opc_t OP_SHL = opc_t'(10);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    typedef struct packed {
        logic ir_load;
        logic extra;
        logic wren;
        logic mux1;
        logic mux3;
        logic mux3_all;
        logic pc_sload;
        logic pc_cnt_en;
        logic acc_en;
        logic acc_load;
        logic addsub;
    } strobes_t;

    state_t   state;
    state_t   state_nxt;
    logic     err_q;
    logic     err_set;
    strobes_t stb;
    strobes_t stb_out;

    // State register and sticky illegal-opcode flag; RESET has priority.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state <= S_FETCH;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state and raw strobe decode from state, opcode, flags and MEM_RDY.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_nxt = state;
        stb       = '0;
        err_set   = 1'b0;

        case (state)
            S_FETCH: begin
                stb.ir_load = bus.MEM_RDY;
                if (bus.MEM_RDY) begin
                    state_nxt = S_EXEC1;
                end
            end

            S_EXEC1: begin
                state_nxt = S_FETCH;
                case (bus.IR)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        // Operand address on the RAM bus until read data is valid.
                        stb.mux1  = 1'b1;
                        stb.extra = 1'b1;
                        state_nxt = bus.MEM_RDY ? S_EXEC2 : S_EXEC1;
                    end
                    OP_STA: begin
                        stb.mux1      = 1'b1;
                        stb.wren      = 1'b1;
                        stb.pc_cnt_en = 1'b1;
                    end
                    OP_JMP: stb.pc_sload = 1'b1;
                    OP_JMI: begin
                        stb.pc_sload  = bus.MI;
                        stb.pc_cnt_en = !bus.MI;
                    end
                    OP_JEQ: begin
                        stb.pc_sload  = bus.EQ;
                        stb.pc_cnt_en = !bus.EQ;
                    end
                    OP_JNE: begin
                        stb.pc_sload  = !bus.EQ;
                        stb.pc_cnt_en = bus.EQ;
                    end
                    OP_LDI: begin
                        stb.mux3      = 1'b1;
                        stb.acc_en    = 1'b1;
                        stb.acc_load  = 1'b1;
                        stb.pc_cnt_en = 1'b1;
                    end
                    OP_SHL: begin
                        stb.acc_en    = 1'b1;
                        stb.pc_cnt_en = 1'b1;
                    end
                    OP_STP: state_nxt = S_HALT;
                    default: begin
                        err_set = 1'b1;
                        if (HALT_ON_ILLEGAL) begin
                            state_nxt = S_HALT;
                        end else begin
                            stb.pc_cnt_en = 1'b1;
                        end
                    end
                endcase
            end

            S_EXEC2: begin
                state_nxt = S_FETCH;
                case (bus.IR)
                    OP_LDA: begin
                        stb.mux3      = 1'b1;
                        stb.mux3_all  = 1'b1;
                        stb.acc_en    = 1'b1;
                        stb.acc_load  = 1'b1;
                        stb.pc_cnt_en = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        stb.acc_en    = 1'b1;
                        stb.acc_load  = 1'b1;
                        stb.addsub    = (bus.IR == OP_ADD);
                        stb.pc_cnt_en = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_HALT: begin
                // Resuming steps the PC past the halting instruction.
                if (bus.RUN) begin
                    stb.pc_cnt_en = 1'b1;
                    state_nxt     = S_FETCH;
                end
            end

            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset aborts the current cycle: no strobe may reach the datapath.
    assign stb_out = RESET ? strobes_t'('0) : stb;

    assign bus.FETCH           = (state == S_FETCH);
    assign bus.EXEC1           = (state == S_EXEC1);
    assign bus.EXEC2           = (state == S_EXEC2);
    assign bus.HALTED          = (state == S_HALT);

    assign bus.IR_LOAD         = stb_out.ir_load;
    assign bus.EXTRA           = stb_out.extra;
    assign bus.Wren            = stb_out.wren;
    assign bus.MUX1            = stb_out.mux1;
    assign bus.MUX3            = stb_out.mux3;
    assign bus.MUX3_useAllBits = stb_out.mux3_all;
    assign bus.PC_sload        = stb_out.pc_sload;
    assign bus.PC_cnt_en       = stb_out.pc_cnt_en;
    assign bus.ACC_EN          = stb_out.acc_en;
    assign bus.ACC_LOAD        = stb_out.acc_load;
    assign bus.ADDSUB          = stb_out.addsub;
    assign bus.ACC_SHIFTIN     = 1'b0;
    assign bus.ERR             = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer. dut0: OPC_W=4, illegal opcodes act as NOP.
// dut1: OPC_W=5, illegal opcodes halt (wide IR must not alias).
// Each instruction is summarised (latency, strobe pulse counts, hold-cycle
// behaviour, end state) and compared with totals derived from opcode rules.
module tb_ctrl_sequencer;

    localparam logic [10:0] B_IRL    = 11'h400;
    localparam logic [10:0] B_EXTRA  = 11'h200;
    localparam logic [10:0] B_WREN   = 11'h100;
    localparam logic [10:0] B_MUX1   = 11'h080;
    localparam logic [10:0] B_MUX3   = 11'h040;
    localparam logic [10:0] B_ALL    = 11'h020;
    localparam logic [10:0] B_SLOAD  = 11'h010;
    localparam logic [10:0] B_PCCNT  = 11'h008;
    localparam logic [10:0] B_ACCEN  = 11'h004;
    localparam logic [10:0] B_ACCLD  = 11'h002;
    localparam logic [10:0] B_ADDSUB = 11'h001;
    localparam logic [10:0] B_ACTION = B_IRL | B_WREN | B_SLOAD | B_PCCNT | B_ACCEN | B_ACCLD;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   err_model = 1'b0;

    ctrl_sequencer_if #(.OPC_W(4)) bus0 ();
    ctrl_sequencer_if #(.OPC_W(5)) bus1 ();

    ctrl_sequencer #(.OPC_W(4), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus0)
    );

    ctrl_sequencer #(.OPC_W(5), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [10:0] stb0();
        return {bus0.IR_LOAD, bus0.EXTRA, bus0.Wren, bus0.MUX1, bus0.MUX3,
                bus0.MUX3_useAllBits, bus0.PC_sload, bus0.PC_cnt_en,
                bus0.ACC_EN, bus0.ACC_LOAD, bus0.ADDSUB};
    endfunction

    function automatic logic [10:0] stb1();
        return {bus1.IR_LOAD, bus1.EXTRA, bus1.Wren, bus1.MUX1, bus1.MUX3,
                bus1.MUX3_useAllBits, bus1.PC_sload, bus1.PC_cnt_en,
                bus1.ACC_EN, bus1.ACC_LOAD, bus1.ADDSUB};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold dut0 in HALT for n cycles, then resume with RUN.
    task automatic release_halt(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus0.RUN     = 1'b0;
            bus0.MEM_RDY = 1'($urandom);
            bus0.IR      = 4'($urandom);
            #2;
            check({tag, ":halt_hold"}, 32'(bus0.HALTED), 1);
            check({tag, ":halt_quiet"}, 32'(stb0()), 0);
            next_cycle();
        end
        bus0.RUN = 1'b1;
        #2;
        check({tag, ":resume"}, 32'(stb0()), 32'(B_PCCNT));
        next_cycle();
        bus0.RUN = 1'b0;
        #1;
        check({tag, ":after_resume"}, 32'(bus0.FETCH), 1);
    endtask

    // One instruction on dut0: wf fetch wait cycles, we operand wait cycles.
    task automatic run_instr(input int opc, input bit eq, input bit mi,
                             input int wf, input int we, input int halt_n,
                             input string tag);
        bit mem_op = (opc == 0) || (opc == 2) || (opc == 3);
        bit illegal = (opc > 10);
        bit taken = (opc == 4) || (opc == 5 && mi) || (opc == 6 && eq) || (opc == 9 && !eq);
        bit halts = (opc == 7);
        bit hold;
        bit done = 1'b0;
        int cyc = 0;
        int n_cyc = 0, n_irl = 0, n_pc = 0, n_sl = 0, n_acc = 0, n_ld = 0, n_wr = 0;
        int n_add = 0, n_m3 = 0, n_all = 0, n_m1 = 0, n_hold_bad = 0, n_hold_mx = 0;
        int n_both = 0, n_shift = 0;
        logic [10:0] s;

        check({tag, ":start"}, 32'(bus0.FETCH), 1);
        while (!done && cyc < 64) begin
            bus0.IR  = 4'(opc);
            bus0.EQ  = eq;
            bus0.MI  = mi;
            bus0.RUN = 1'($urandom);
            hold = 1'b0;
            if (cyc < wf) begin
                bus0.MEM_RDY = 1'b0;
                hold = 1'b1;
            end else if (cyc == wf) begin
                bus0.MEM_RDY = 1'b1;
            end else if (mem_op && cyc <= wf + we) begin
                bus0.MEM_RDY = 1'b0;
                hold = 1'b1;
            end else if (mem_op && cyc == wf + we + 1) begin
                bus0.MEM_RDY = 1'b1;
            end else begin
                bus0.MEM_RDY = 1'($urandom);
            end
            #2;
            s = stb0();
            n_cyc++;
            n_irl   += int'((s & B_IRL) != 0);
            n_pc    += int'((s & B_PCCNT) != 0);
            n_sl    += int'((s & B_SLOAD) != 0);
            n_acc   += int'((s & B_ACCEN) != 0);
            n_ld    += int'((s & B_ACCLD) != 0);
            n_wr    += int'((s & B_WREN) != 0);
            n_add   += int'((s & B_ADDSUB) != 0);
            n_m3    += int'((s & B_MUX3) != 0);
            n_all   += int'((s & B_ALL) != 0);
            n_both  += int'((s & B_SLOAD) != 0 && (s & B_PCCNT) != 0);
            n_shift += int'(bus0.ACC_SHIFTIN !== 1'b0);
            if (hold) begin
                n_hold_bad += int'((s & B_ACTION) != 0);
                n_hold_mx  += int'(cyc > wf && (s & (B_MUX1 | B_EXTRA)) == (B_MUX1 | B_EXTRA));
            end else if (!mem_op) begin
                n_m1 += int'((s & B_MUX1) != 0);
            end
            next_cycle();
            cyc++;
            done = (cyc > wf) && (bus0.FETCH || bus0.HALTED);
        end

        check({tag, ":finished"}, 32'(done), 1);
        check({tag, ":latency"}, n_cyc, wf + (mem_op ? 3 + we : 2));
        check({tag, ":ir_load"}, n_irl, 1);
        check({tag, ":pc_cnt_en"}, n_pc, (halts || taken || (opc == 4)) ? 0 : 1);
        check({tag, ":pc_sload"}, n_sl, taken ? 1 : 0);
        check({tag, ":acc_en"}, n_acc, (mem_op || opc == 8 || opc == 10) ? 1 : 0);
        check({tag, ":acc_load"}, n_ld, (mem_op || opc == 8) ? 1 : 0);
        check({tag, ":wren"}, n_wr, (opc == 1) ? 1 : 0);
        check({tag, ":addsub"}, n_add, (opc == 2) ? 1 : 0);
        check({tag, ":mux3"}, n_m3, (opc == 0 || opc == 8) ? 1 : 0);
        check({tag, ":mux3_all"}, n_all, (opc == 0) ? 1 : 0);
        check({tag, ":mux1"}, n_m1, (opc == 1) ? 1 : 0);
        check({tag, ":hold_quiet"}, n_hold_bad, 0);
        check({tag, ":hold_mux_extra"}, n_hold_mx, mem_op ? we : 0);
        check({tag, ":pc_exclusive"}, n_both, 0);
        check({tag, ":shiftin"}, n_shift, 0);
        err_model = err_model | illegal;
        check({tag, ":err"}, 32'(bus0.ERR), 32'(err_model));
        check({tag, ":end_state"}, 32'(halts ? bus0.HALTED : bus0.FETCH), 1);
        if (halts) begin
            release_halt(tag, halt_n);
        end
    endtask

    initial begin
        bus0.IR = '0; bus0.EQ = 1'b0; bus0.MI = 1'b0; bus0.MEM_RDY = 1'b1; bus0.RUN = 1'b0;
        bus1.IR = '0; bus1.EQ = 1'b0; bus1.MI = 1'b0; bus1.MEM_RDY = 1'b1; bus1.RUN = 1'b0;
        reset = 1'b1;

        // Reset: FETCH with IR_LOAD suppressed although MEM_RDY=1.
        next_cycle();
        #2;
        check("rst_fetch", 32'(bus0.FETCH), 1);
        check("rst_quiet", 32'(stb0()), 0);
        check("rst_err", 32'(bus0.ERR), 0);
        check("rst_shiftin", 32'(bus0.ACC_SHIFTIN), 0);

        // LDA with no waits, cycle by cycle.
        reset = 1'b0;
        bus0.IR = 4'd0;
        #2;
        check("lda_f_state", 32'(bus0.FETCH), 1);
        check("lda_f_stb", 32'(stb0()), 32'(B_IRL));
        next_cycle();
        #1;
        check("lda_e1_state", 32'(bus0.EXEC1), 1);
        check("lda_e1_mux1", 32'(stb0() & B_MUX1), 32'(B_MUX1));
        check("lda_e1_noact", 32'(stb0() & B_ACTION), 0);
        next_cycle();
        #1;
        check("lda_e2_state", 32'(bus0.EXEC2), 1);
        check("lda_e2_stb", 32'(stb0()), 32'(B_MUX3 | B_ALL | B_ACCEN | B_ACCLD | B_PCCNT));
        next_cycle();
        #1;
        check("lda_back", 32'(bus0.FETCH), 1);

        // Directed instruction mix.
        run_instr(2, 1'b0, 1'b0, 0, 2, 0, "add_wait2");
        run_instr(3, 1'b0, 1'b0, 1, 0, 0, "sub");
        run_instr(6, 1'b1, 1'b0, 0, 0, 0, "jeq_taken");
        run_instr(6, 1'b0, 1'b0, 0, 0, 0, "jeq_not");
        run_instr(9, 1'b1, 1'b0, 0, 0, 0, "jne_not");
        run_instr(9, 1'b0, 1'b0, 0, 0, 0, "jne_taken");
        run_instr(5, 1'b0, 1'b1, 0, 0, 0, "jmi_taken");
        run_instr(5, 1'b0, 1'b0, 0, 0, 0, "jmi_not");
        run_instr(4, 1'b0, 1'b0, 0, 0, 0, "jmp");
        run_instr(1, 1'b0, 1'b0, 2, 0, 0, "sta");
        run_instr(8, 1'b0, 1'b0, 0, 0, 0, "ldi");
        run_instr(10, 1'b0, 1'b0, 0, 0, 0, "shl");
        run_instr(7, 1'b0, 1'b0, 0, 0, 5, "stp");
        run_instr(11, 1'b0, 1'b0, 0, 0, 0, "illegal11");
        run_instr(0, 1'b0, 1'b0, 0, 1, 0, "lda_after_ill");

        // Random instruction stream.
        for (int i = 0; i < 80; i++) begin
            run_instr($urandom_range(0, 15), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(1, 4), "rand");
        end

        // Reset in EXEC1 of SUB aborts it and clears ERR.
        if (!err_model) run_instr(12, 1'b0, 1'b0, 0, 0, 0, "set_err");
        bus0.IR = 4'd3;
        bus0.MEM_RDY = 1'b1;
        #2;
        next_cycle();
        reset = 1'b1;
        #2;
        check("rst_mid_quiet", 32'(stb0()), 0);
        next_cycle();
        reset = 1'b0;
        err_model = 1'b0;
        #1;
        check("rst_mid_fetch", 32'(bus0.FETCH), 1);
        check("rst_mid_err", 32'(bus0.ERR), 0);

        // dut1: IR=18 would alias to ADD in 4 bits; must halt as illegal.
        reset = 1'b1;
        bus1.IR = 5'd18;
        bus1.MEM_RDY = 1'b1;
        bus1.RUN = 1'b0;
        next_cycle();
        reset = 1'b0;
        #2;
        check("d1_fetch", 32'(bus1.FETCH), 1);
        next_cycle();
        #1;
        check("d1_exec1", 32'(bus1.EXEC1), 1);
        check("d1_exec1_quiet", 32'(stb1()), 0);
        check("d1_err_before", 32'(bus1.ERR), 0);
        next_cycle();
        #1;
        check("d1_halted", 32'(bus1.HALTED), 1);
        check("d1_err", 32'(bus1.ERR), 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("d1_hold", 32'(bus1.HALTED), 1);
            check("d1_hold_quiet", 32'(stb1()), 0);
            next_cycle();
        end
        bus1.RUN = 1'b1;
        #2;
        check("d1_resume", 32'(stb1()), 32'(B_PCCNT));
        next_cycle();
        bus1.RUN = 1'b0;
        #1;
        check("d1_after_resume", 32'(bus1.FETCH), 1);
        check("d1_err_sticky", 32'(bus1.ERR), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
